// File: rtl/prog_timer.sv
// Programmable down-counting tick timer with periodic or one-shot terminal pulse.
// Latency: every output is registered, one clock edge after the inputs that cause it.
// Backpressure: none; enable qualifies ticks, and stop/start/load take effect on the next edge.
module prog_timer #(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic             zero,
    output logic             running,
    output logic [WIDTH-1:0] count
);

    // A zero or oversized reset period would make the counter underflow or truncate.
    if (DEFAULT_PERIOD < 1 || longint'(DEFAULT_PERIOD) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_default
        $error("prog_timer: DEFAULT_PERIOD out of range 1..2^WIDTH-1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_PERIOD  = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] RST_COUNT   = WIDTH'(DEFAULT_PERIOD - 1);

    state_t           state_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] count_q;
    logic             zero_q;
    logic             running_q;

    logic             load_ok;
    logic [WIDTH-1:0] period_d;
    logic [WIDTH-1:0] reload_d;

    // A zero period load is discarded; a valid same-cycle load is already the reload source.
    always_comb begin
        load_ok  = load && (period_in != '0);
        period_d = load_ok ? period_in : period_q;
        reload_d = period_d - ONE;
    end

    // Control FSM and counter datapath: reset > stop > start > terminal/decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            period_q  <= RST_PERIOD;
            count_q   <= RST_COUNT;
            zero_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            period_q <= period_d;
            zero_q   <= 1'b0;
            if (stop) begin
                state_q   <= S_IDLE;
                running_q <= 1'b0;
                // Loading while already idle still refreshes the visible count.
                if (state_q == S_IDLE && load_ok) begin
                    count_q <= reload_d;
                end
            end else if (start) begin
                state_q   <= S_RUN;
                running_q <= 1'b1;
                count_q   <= reload_d;
            end else if (state_q == S_RUN) begin
                if (enable) begin
                    if (count_q == '0) begin
                        zero_q  <= 1'b1;
                        count_q <= reload_d;
                        if (mode) begin
                            state_q   <= S_IDLE;
                            running_q <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q - ONE;
                    end
                end
            end else if (load_ok) begin
                // Idle: the count tracks a newly loaded period so it is ready to start.
                count_q <= reload_d;
            end
        end
    end

    assign zero    = zero_q;
    assign running = running_q;
    assign count   = count_q;

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer: each stimulus cycle queues its hand-computed expected outputs.
// A monitor samples 1 time unit after every rising edge and compares against the queue head.
// Runs a fixed vector list, then drains the queue within a bounded number of cycles.
module tb_prog_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] period_in = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        zero;
    logic        running;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    typedef struct {
        logic        z;
        logic        r;
        logic [15:0] c;
        int          id;
    } exp_t;

    exp_t exp_q[$];

    prog_timer #(.WIDTH(16), .DEFAULT_PERIOD(1000)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .period_in (period_in),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .zero      (zero),
        .running   (running),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic rst, input logic en, input logic ld, input logic [15:0] pin,
                        input logic md, input logic st, input logic sp,
                        input logic ez, input logic er, input logic [15:0] ec);
        exp_t e;
        reset     = rst;
        enable    = en;
        load      = ld;
        period_in = pin;
        mode      = md;
        start     = st;
        stop      = sp;
        e.z  = ez;
        e.r  = er;
        e.c  = ec;
        e.id = step_no;
        exp_q.push_back(e);
        step_no++;
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are registered, so every edge presents a new response to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (zero !== e.z) begin
                    errors++;
                    $display("FAIL zero step %0d: got %b expected %b", e.id, zero, e.z);
                end
                checks++;
                if (running !== e.r) begin
                    errors++;
                    $display("FAIL running step %0d: got %b expected %b", e.id, running, e.r);
                end
                checks++;
                if (count !== e.c) begin
                    errors++;
                    $display("FAIL count step %0d: got %0d expected %0d", e.id, count, e.c);
                end
            end
        end
    end

    initial begin
        #2;
        // Reset held two cycles with start asserted, then 20 idle cycles with no pulse.
        //   rst en ld pin md st sp   z r count
        step(1, 1, 0, 0, 0, 1, 0,   0, 0, 999);
        step(1, 1, 0, 0, 0, 1, 0,   0, 0, 999);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 999);

        // Periodic P=4: pulses after edges t+4, t+8, t+12.
        step(0, 0, 1, 4, 0, 0, 0,   0, 0, 3);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
            step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
            step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            step(0, 1, 0, 0, 0, 0, 0, 1, 1, 3);
        end
        step(0, 1, 0, 0, 0, 0, 1,   0, 0, 3);

        // One-shot P=3 with enable toggling: single pulse on the 3rd enabled edge.
        step(0, 0, 1, 3, 1, 0, 0,   0, 0, 2);
        step(0, 1, 0, 0, 1, 1, 0,   0, 1, 2);
        step(0, 1, 0, 0, 1, 0, 0,   0, 1, 1);
        step(0, 0, 0, 0, 1, 0, 0,   0, 1, 1);
        step(0, 1, 0, 0, 1, 0, 0,   0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0,   0, 1, 0);
        step(0, 1, 0, 0, 1, 0, 0,   1, 0, 2);
        step(0, 0, 0, 0, 1, 0, 0,   0, 0, 2);
        step(0, 1, 0, 0, 1, 0, 0,   0, 0, 2);
        step(0, 0, 0, 0, 1, 0, 0,   0, 0, 2);

        // Mid-run load: P=5 then load 2 at count=3; zero-period loads ignored.
        step(0, 0, 1, 5, 0, 0, 0,   0, 0, 4);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 4);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 3);
        step(0, 1, 1, 2, 0, 0, 0,   0, 1, 2);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 1);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0,   1, 1, 1);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0,   1, 1, 1);
        step(0, 1, 1, 0, 0, 0, 0,   0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0,   1, 1, 1);
        step(0, 1, 0, 0, 0, 0, 1,   0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0,   0, 0, 1);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1,   0, 0, 1);

        // Conflicts: stop beats start (idle and running).
        step(0, 1, 0, 0, 0, 1, 1,   0, 0, 1);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 1);
        step(0, 1, 0, 0, 0, 1, 1,   0, 0, 1);
        // Stop on the terminal edge: no pulse, count stays 0.
        step(0, 0, 1, 3, 0, 0, 0,   0, 0, 2);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 2);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 1);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1,   0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0,   0, 0, 0);
        // Start at count=1 restarts the period without a pulse.
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 2);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 1);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 2);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 1);
        step(0, 1, 0, 0, 0, 0, 0,   0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0,   1, 1, 2);

        // Reset mid-run at count=2 overrides every other input.
        step(1, 1, 1, 7, 0, 1, 0,   0, 0, 999);
        step(0, 1, 0, 0, 0, 0, 0,   0, 0, 999);

        // P=1 periodic: pulse on every enabled cycle, count pinned at 0.
        step(0, 0, 1, 1, 0, 0, 0,   0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0,   0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0,   0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1,   0, 0, 0);

        // Let the monitor drain; a stuck queue counts as a failure.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
# prog_timer

Runtime-programmable down-counting timer: next generation of the fixed-period tick divider used for strobe generation across the lab designs. Adds a run-time loadable period, start/stop control, periodic or one-shot mode and a visible count. Feeds periodic strobes to display scanners, debouncers and sample timers.

## Interface

**Parameters**
- `WIDTH`, default 16: width of the period register and the counter.
- `DEFAULT_PERIOD`, default 1000: period loaded at reset. Legal range is 1 to 2^WIDTH-1; values outside it are an elaboration error.

**Ports** (one clock; reset is synchronous and active-high)
- `clk` in, 1: clock; all state changes on its rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `enable` in, 1: tick qualifier; the counter decrements only on cycles with `enable`=1.
- `load` in, 1: strobe that writes `period_in` into the period register.
- `period_in` in, WIDTH: new period P. Value 0 is illegal.
- `mode` in, 1: 0 = periodic, 1 = one-shot. Sampled every cycle in RUN.
- `start` in, 1: begin or restart counting.
- `stop` in, 1: halt counting.
- `zero` out, 1: registered one-cycle terminal-count pulse.
- `running` out, 1: high while in RUN.
- `count` out, WIDTH: current counter value.

## Operation

- **Reset:** `period_reg`=DEFAULT_PERIOD, `count`=DEFAULT_PERIOD-1, state IDLE, `zero`=0, `running`=0.
- **States:** IDLE and RUN. `running` is 1 in RUN and 0 in IDLE, registered.
- **Load:** when `load`=1 and `period_in`≠0, then `period_reg`←`period_in`.
  - If `period_in`=0, the load is ignored entirely; no register changes.
  - In IDLE, a valid load also sets `count`←`period_in`-1.
  - In RUN, `count` is untouched. The new period takes effect at the next reload.
- **Start:** from IDLE or RUN, the next state is RUN and `count`←P-1.
  - P is the effective period: `period_in` if a valid `load` occurs in the same cycle, otherwise `period_reg`.
  - `start` in RUN restarts the period and produces no `zero` pulse.
- **Stop:** the next state is IDLE and `count` holds its value. `zero` is 0 on the next cycle.
- **Priority:** `reset` > `stop` > `start` > terminal/decrement. `load` is applied alongside any of these except `reset`.
- **RUN with `enable`=1:**
  - If `count`≠0: `count`←`count`-1.
  - If `count`=0: `zero`←1 and `count`←`period_reg`-1. `period_reg` here already includes a same-cycle valid load.
  - If `mode`=1 at the terminal cycle, the state also goes to IDLE.
- **RUN with `enable`=0:** `count` holds and `zero`←0.
- **IDLE:** `count` holds except on load; `zero`←0; `enable` is ignored.
- **`zero` pulse:** high for exactly the one cycle after the terminal edge, otherwise 0.
- **P=1, periodic:** `count` stays 0 and `zero` is high on every cycle following an enabled cycle.
- **Arithmetic:** unsigned, WIDTH bits. The counter never underflows, because a reload happens at 0.

## Timing

- **Latency:** all outputs are registered, with one-edge latency from any input.
- **Pulse spacing:** `start` at edge t, with `enable` held high, gives `zero`=1 after edge t+P. Periodic pulses then follow every P enabled edges.
- **Enable gaps:** with gaps in `enable`, the spacing is exactly P enabled edges.
- **Stop at terminal:** `stop` on the terminal edge suppresses the pulse, and `count` stays 0.
- **Mode change:** a change of `mode` mid-run is effective at the next terminal count.
- **Reset mid-run:** returns to the reset values on the next edge, regardless of other inputs.

## Test plan

- **Reset values:** assert `reset` 2 cycles with `start`=1. Expect `running`=0, `zero`=0, `count`=999, and no pulse for 20 cycles.
- **Periodic:** load P=4, start, `enable`=1 continuously. Expect `zero` after edges t+4, t+8, t+12, and `count` sequence 3,2,1,0,3.
- **One-shot plus gating:** load P=3, `mode`=1, start, `enable` toggling 1,0,1,0,…. Expect a single `zero` after the 3rd enabled edge, then `running`=0 and `count`=2 held.
- **Mid-run load:** run periodic P=5 and load 2 at `count`=3. Expect the current period to complete (pulse after 5 edges), the next pulse 2 enabled edges later, and a `period_in`=0 load to have no effect.
- **Conflicts:** `stop` and `start` in the same cycle leaves IDLE. `stop` at `count`=0 with `enable`=1 gives no pulse and `count`=0. `start` at `count`=1 restarts at P-1 with no pulse.
- **Reset mid-run and P=1:** reset mid-run at `count`=2 returns the reset values next cycle. Periodic P=1 with `enable`=1 for 6 cycles gives `zero` high 6 consecutive cycles.
